// File: rtl/add_sum_serializer.sv
// Captures a full parallel sum tensor and streams it out one row per valid/ready beat.
// First row one cycle after capture; rows hold under backpressure, done pulses after the last row.
module add_sum_serializer #(
  parameter int ADDER_NUM = 128,
  parameter int DIMENTION = 768,
  parameter int WIDTH_SUM = 8
) (
  input  logic                                    clk_p,
  input  logic                                    rst_p,
  input  logic [ADDER_NUM*DIMENTION*WIDTH_SUM-1:0] sum_in,
  input  logic                                    sum_in_valid,
  output logic                                    sum_in_ready,
  output logic [DIMENTION*WIDTH_SUM-1:0]          row_data,
  output logic                                    row_valid,
  input  logic                                    row_ready,
  output logic [$clog2(ADDER_NUM)-1:0]            row_idx,
  output logic                                    row_last,
  output logic                                    done
);

  localparam int ROW_W = DIMENTION * WIDTH_SUM;
  localparam int IDX_W = $clog2(ADDER_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDER_NUM - 1);

  if (ADDER_NUM < 2) begin : g_param_check
    $error("add_sum_serializer: ADDER_NUM must be >= 2");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic               done_q, done_d;
  logic               capture;
  logic [ROW_W-1:0]   buf_q [ADDER_NUM];

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      done_q    <= done_d;
    end
  end

  // Data buffer carries no reset; it is only read while streaming after a capture.
  always_ff @(posedge clk_p) begin
    if (capture) begin
      for (int i = 0; i < ADDER_NUM; i++) begin
        buf_q[i] <= sum_in[i*ROW_W +: ROW_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    done_d       = 1'b0;
    capture      = 1'b0;
    sum_in_ready = 1'b0;
    row_valid    = 1'b0;
    row_data     = '0;
    row_idx      = '0;
    row_last     = 1'b0;
    case (state_q)
      IDLE: begin
        sum_in_ready = 1'b1;
        if (sum_in_valid) begin
          capture   = 1'b1;
          row_cnt_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        row_valid = 1'b1;
        row_data  = buf_q[row_cnt_q];
        row_idx   = row_cnt_q;
        row_last  = (row_cnt_q == LAST_IDX);
        if (row_ready) begin
          if (row_last) begin
            state_d   = IDLE;
            row_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_add_sum_serializer.sv
// Scoreboard bench for add_sum_serializer with a 4-row, 2-element, 8-bit tensor.
module tb_add_sum_serializer;
  localparam int A = 4;
  localparam int D = 2;
  localparam int W = 8;
  localparam int RW = D * W;

  logic            clk_p = 1'b0;
  logic            rst_p;
  logic [A*RW-1:0] sum_in;
  logic            sum_in_valid;
  logic            sum_in_ready;
  logic [RW-1:0]   row_data;
  logic            row_valid;
  logic            row_ready;
  logic [1:0]      row_idx;
  logic            row_last;
  logic            done;

  add_sum_serializer #(.ADDER_NUM(A), .DIMENTION(D), .WIDTH_SUM(W)) dut (
    .clk_p(clk_p), .rst_p(rst_p), .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .sum_in_ready(sum_in_ready), .row_data(row_data), .row_valid(row_valid),
    .row_ready(row_ready), .row_idx(row_idx), .row_last(row_last), .done(done)
  );

  always #5 clk_p = ~clk_p;

  typedef struct packed {
    logic [RW-1:0] d;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic push_tensor(input logic [A*RW-1:0] t);
    exp_t e;
    for (int i = 0; i < A; i++) begin
      e.d    = t[i*RW +: RW];
      e.idx  = 2'(i);
      e.last = (i == A - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [A*RW-1:0] t);
    sum_in       = t;
    sum_in_valid = 1'b1;
    push_tensor(t);
    tick();
    sum_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk_p);
      if (done) seen = 1'b1;
      else @(posedge clk_p);
    end
    if (!seen) chk("done_timeout", 0, 1);
    tick();
  endtask

  // Accepted beats are compared against the scoreboard; idle outputs must read zero.
  always @(negedge clk_p) begin
    if (!rst_p) begin
      if (done) done_cnt++;
      if (row_valid && row_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_row", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("row_data", 64'(row_data), 64'(e.d));
          chk("row_idx", 64'(row_idx), 64'(e.idx));
          chk("row_last", 64'(row_last), 64'(e.last));
        end
      end else if (!row_valid) begin
        chk("idle_zero", {row_data, row_idx, row_last}, 0);
      end
    end
  end

  localparam logic [A*RW-1:0] T0 = 64'h07_06_05_04_03_02_01_00;
  localparam logic [A*RW-1:0] TF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [A*RW-1:0] TS = 64'h1234_5678_9ABC_7F80;

  initial begin
    int a0, d0;
    rst_p        = 1'b1;
    sum_in       = '0;
    sum_in_valid = 1'b0;
    row_ready    = 1'b0;
    tick();
    tick();
    @(negedge clk_p);
    chk("rst_ready", 64'(sum_in_ready), 1);
    chk("rst_valid", 64'(row_valid), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_data", 64'(row_data), 0);
    tick();
    rst_p     = 1'b0;
    row_ready = 1'b1;
    tick();

    // Back-to-back streaming with exact cycle timing
    d0 = done_cnt;
    send(T0);
    for (int k = 0; k < A; k++) begin
      @(negedge clk_p);
      chk("t2_vld", 64'(row_valid), 1);
      chk("t2_idx", 64'(row_idx), 64'(k));
      chk("t2_busy", 64'(sum_in_ready), 0);
      tick();
    end
    @(negedge clk_p);
    chk("t2_done", 64'(done), 1);
    chk("t2_ready", 64'(sum_in_ready), 1);
    tick();
    chk("t2_one_done", 64'(done_cnt - d0), 1);

    // Backpressure at row 1
    a0 = acc_cnt;
    d0 = done_cnt;
    send(T0);
    tick();
    row_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_p);
      chk("t3_hold_data", 64'(row_data), 64'h0302);
      chk("t3_hold_idx", 64'(row_idx), 1);
      chk("t3_hold_vld", 64'(row_valid), 1);
      tick();
    end
    row_ready = 1'b1;
    @(negedge clk_p);
    chk("t3_resume", 64'(row_data), 64'h0302);
    tick();
    @(negedge clk_p);
    chk("t3_row2", 64'(row_data), 64'h0504);
    wait_done();
    chk("t3_accepts", 64'(acc_cnt - a0), 4);
    chk("t3_dones", 64'(done_cnt - d0), 1);

    // New tensor offered during STREAM is ignored until the done cycle
    sum_in       = T0;
    sum_in_valid = 1'b1;
    push_tensor(T0);
    tick();
    sum_in = TF;
    push_tensor(TF);
    for (int k = 0; k < A; k++) tick();
    @(negedge clk_p);
    chk("t4_done", 64'(done), 1);
    chk("t4_ready", 64'(sum_in_ready), 1);
    tick();
    sum_in_valid = 1'b0;
    @(negedge clk_p);
    chk("t4_new_vld", 64'(row_valid), 1);
    chk("t4_new_row0", 64'(row_data), 64'hFFFF);
    wait_done();

    // Reset while row 2 is presented
    d0 = done_cnt;
    send(T0);
    tick();
    tick();
    @(negedge clk_p);
    chk("t5_at_row2", 64'(row_idx), 2);
    tick();
    rst_p = 1'b1;
    exp_q.delete();
    tick();
    rst_p = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_p);
      chk("t5_no_vld", 64'(row_valid), 0);
      chk("t5_ready", 64'(sum_in_ready), 1);
      tick();
    end
    chk("t5_no_done", 64'(done_cnt - d0), 0);
    send(T0);
    @(negedge clk_p);
    chk("t5_restart_idx", 64'(row_idx), 0);
    wait_done();

    // Signed elements pass through bit-exact
    send(TS);
    @(negedge clk_p);
    chk("t6_signed", 64'(row_data), 64'h7F80);
    wait_done();

    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
